// File: rtl/matrix_scroll_writer.sv
// Scrolling frame source: streams NUM_COLS pattern-RAM columns into a dot-matrix
// column store each frame, then holds and advances the scroll offset by one column.
//
// state | meaning
// IDLE  | waiting for START with a non-zero pattern length
// CLEAR | clear strobe to the column store; column 0 address already on the RAM
// FETCH | read address for the current column presented to the RAM
// WRITE | RAM data valid; registered into the LOAD strobe
// HOLD  | frame written, counting hold cycles before the next offset step
module matrix_scroll_writer #(
    parameter int  NUM_COLS    = 32,
    parameter int  ROW_W       = 16,
    parameter int  ADDR_W      = 8,
    parameter int  HOLD_CYCLES = 1000,
    localparam int COL_W       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] pat_len_i,
    output logic [ADDR_W-1:0] pat_addr_o,
    input  logic [ROW_W-1:0]  pat_data_i,
    output logic [COL_W-1:0]  column_id_o,
    output logic [ROW_W-1:0]  in_column_o,
    output logic              load_o,
    output logic              in_clr_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WRITE,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              stop_req_q, stop_req_d;

    logic [ADDR_W-1:0] pat_addr_q, pat_addr_d;
    logic [COL_W-1:0]  column_id_q, column_id_d;
    logic [ROW_W-1:0]  in_column_q, in_column_d;
    logic              load_q, load_d;
    logic              in_clr_q, in_clr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              start_ok;
    logic              last_col;
    logic              hold_done;
    logic              stop_pend;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] offset_inc;

    // Increment modulo lim without ever forming offset+col; v is always < lim.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] v,
                                                   input logic [ADDR_W-1:0] lim);
        logic [ADDR_W:0] s;
        s = {1'b0, v} + (ADDR_W + 1)'(1);
        return (s == {1'b0, lim}) ? '0 : s[ADDR_W-1:0];
    endfunction

    assign start_ok   = start_i && (pat_len_i != '0);
    assign last_col   = (col_q == LAST_COL);
    assign hold_done  = (hold_cnt_q == HOLD_LAST);
    assign stop_pend  = stop_req_q || stop_i;
    assign ptr_inc    = wrap_inc(ptr_q, len_q);
    assign offset_inc = wrap_inc(offset_q, len_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok) state_d = S_CLEAR;
            S_CLEAR: state_d = S_WRITE;
            S_FETCH: state_d = S_WRITE;
            S_WRITE: state_d = last_col ? S_HOLD : S_FETCH;
            S_HOLD:  if (hold_done) state_d = stop_pend ? S_IDLE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        offset_d     = offset_q;
        ptr_d        = ptr_q;
        col_d        = col_q;
        hold_cnt_d   = hold_cnt_q;
        stop_req_d   = stop_req_q;
        pat_addr_d   = pat_addr_q;
        column_id_d  = column_id_q;
        in_column_d  = in_column_q;
        load_d       = 1'b0;
        in_clr_d     = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = (state_d != S_IDLE);

        if (state_q != S_IDLE && stop_i) begin
            stop_req_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // START beats a simultaneous STOP, which then limits the run to one frame
                if (start_ok) begin
                    len_d      = pat_len_i;
                    offset_d   = '0;
                    col_d      = '0;
                    ptr_d      = '0;
                    pat_addr_d = '0;
                    in_clr_d   = 1'b1;
                    stop_req_d = stop_i;
                end
            end
            S_WRITE: begin
                load_d      = 1'b1;
                column_id_d = col_q;
                in_column_d = pat_data_i;
                if (last_col) begin
                    frame_done_d = 1'b1;
                    hold_cnt_d   = '0;
                end else begin
                    col_d      = col_q + COL_W'(1);
                    ptr_d      = ptr_inc;
                    pat_addr_d = ptr_inc;
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    if (stop_pend) begin
                        stop_req_d = 1'b0;
                    end else begin
                        offset_d   = offset_inc;
                        col_d      = '0;
                        ptr_d      = offset_inc;
                        pat_addr_d = offset_inc;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_q        <= '0;
            offset_q     <= '0;
            ptr_q        <= '0;
            col_q        <= '0;
            hold_cnt_q   <= '0;
            stop_req_q   <= 1'b0;
            pat_addr_q   <= '0;
            column_id_q  <= '0;
            in_column_q  <= '0;
            load_q       <= 1'b0;
            in_clr_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            len_q        <= len_d;
            offset_q     <= offset_d;
            ptr_q        <= ptr_d;
            col_q        <= col_d;
            hold_cnt_q   <= hold_cnt_d;
            stop_req_q   <= stop_req_d;
            pat_addr_q   <= pat_addr_d;
            column_id_q  <= column_id_d;
            in_column_q  <= in_column_d;
            load_q       <= load_d;
            in_clr_q     <= in_clr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pat_addr_o   = pat_addr_q;
    assign column_id_o  = column_id_q;
    assign in_column_o  = in_column_q;
    assign load_o       = load_q;
    assign in_clr_o     = in_clr_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_matrix_scroll_writer.sv
// Directed bench for matrix_scroll_writer with a pattern-RAM model and a
// scoreboard of expected column loads.
module tb_matrix_scroll_writer;

    localparam int NC   = 32;
    localparam int RW   = 16;
    localparam int AW   = 8;
    localparam int HOLD = 4;
    localparam int CW   = $clog2(NC);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [AW-1:0] pat_len;
    logic [AW-1:0] pat_addr;
    logic [RW-1:0] pat_data;
    logic [CW-1:0] column_id;
    logic [RW-1:0] in_column;
    logic          load;
    logic          in_clr;
    logic          busy;
    logic          frame_done;

    matrix_scroll_writer #(
        .NUM_COLS   (NC),
        .ROW_W      (RW),
        .ADDR_W     (AW),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .pat_len_i   (pat_len),
        .pat_addr_o  (pat_addr),
        .pat_data_i  (pat_data),
        .column_id_o (column_id),
        .in_column_o (in_column),
        .load_o      (load),
        .in_clr_o    (in_clr),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [RW-1:0] ram [256];
    always @(posedge clk) pat_data <= ram[pat_addr];

    typedef struct packed {
        logic [CW-1:0] col;
        logic [RW-1:0] data;
        logic          fd;
    } exp_t;

    exp_t exp_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int load_cnt  = 0;
    int clr_cnt   = 0;
    int fd_cnt    = 0;
    int last_cyc  = 0;
    bit last_valid = 0;
    int lc_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int len, input int off);
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            e.col  = CW'(c);
            e.data = RW'((off + c) % len);
            e.fd   = (c == NC - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_frames(input int n, input int lim);
        for (int i = 0; i < lim && fd_cnt < n; i++) tick();
        check("wait_frames", 32'(fd_cnt >= n), 1);
    endtask

    task automatic wait_col_load(input int c, input int lim);
        bit found;
        found = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (load === 1'b1 && column_id == CW'(c)) begin
                found = 1;
                break;
            end
        end
        check("wait_col_load", 32'(found), 1);
    endtask

    task automatic wait_fd(input int lim);
        bit found;
        found = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("wait_frame_done", 32'(found), 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy !== 1'b0; i++) tick();
        check("wait_idle", 32'(busy), 0);
    endtask

    // Scoreboard side: every LOAD must match the next expected column.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (in_clr === 1'b1) clr_cnt++;
        if (frame_done === 1'b1) begin
            fd_cnt++;
            check("fd_with_load", 32'(load), 1);
        end
        if (load === 1'b1) begin
            load_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("column_id", 32'(column_id), 32'(e.col));
                check("in_column", 32'(in_column), 32'(e.data));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                if (last_valid)
                    check("load_spacing", 32'(cyc - last_cyc), (e.col == '0) ? HOLD + 2 : 2);
            end
            last_cyc   = cyc;
            last_valid = 1;
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pat_len = '0;
        for (int i = 0; i < 256; i++) ram[i] = RW'(i);

        repeat (3) tick();
        check("rst_ctrl", 32'({load, in_clr, busy, frame_done}), 0);
        check("rst_addr", 32'(pat_addr), 0);
        check("rst_col", 32'({column_id, in_column}), 0);
        rst_n = 1'b1;
        tick();

        // STOP alone in IDLE does nothing
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("stop_idle_busy", 32'(busy), 0);

        // zero pattern length: START ignored
        pat_len = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("len0_busy", 32'(busy), 0);
        check("len0_clr", 32'(clr_cnt), 0);

        // long pattern, ten scrolled frames with wrap in the tenth
        pat_len = AW'(40);
        for (int f = 0; f < 10; f++) push_frame(40, f);
        last_valid = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clr", 32'(in_clr), 1);
        check("start_busy", 32'(busy), 1);
        tick();
        check("k2_quiet", 32'({load, in_clr}), 0);
        tick();
        check("k3_load", 32'(load), 1);

        wait_frames(2, 400);
        pat_len = AW'(5);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        pat_len = AW'(40);

        wait_frames(9, 1000);
        wait_col_load(10, 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_fd(200);
        tick();
        tick();
        tick();
        check("hold_busy", 32'(busy), 1);
        tick();
        check("stop_busy_drop", 32'(busy), 0);
        check("run1_sb_empty", 32'(exp_q.size()), 0);
        check("run1_loads", 32'(load_cnt), 320);
        check("run1_frames", 32'(fd_cnt), 10);
        check("run1_clr", 32'(clr_cnt), 1);
        repeat (80) tick();
        check("run1_no_extra", 32'(load_cnt), 320);

        // short pattern shorter than the frame; fourth frame starts at offset 3
        pat_len = AW'(5);
        for (int f = 0; f < 4; f++) push_frame(5, f);
        last_valid = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_frames(13, 1000);
        wait_col_load(10, 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_fd(200);
        wait_idle(20);
        check("run2_sb_empty", 32'(exp_q.size()), 0);
        check("run2_frames", 32'(fd_cnt), 14);
        check("run2_clr", 32'(clr_cnt), 2);

        // reset in the middle of a frame
        pat_len = AW'(40);
        push_frame(40, 0);
        last_valid = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_col_load(5, 200);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({load, in_clr, busy, frame_done}), 0);
        check("midrst_addr", 32'(pat_addr), 0);
        check("midrst_col", 32'({column_id, in_column}), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // restart with START and STOP together: exactly one frame
        pat_len = AW'(7);
        push_frame(7, 0);
        last_valid = 0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("restart_clr", 32'(in_clr), 1);
        wait_fd(200);
        wait_idle(20);
        check("one_frame_sb_empty", 32'(exp_q.size()), 0);
        check("one_frame_count", 32'(fd_cnt), 15);
        lc_snap = load_cnt;
        repeat (80) tick();
        check("one_frame_no_extra", 32'(load_cnt), 32'(lc_snap));
        check("final_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
